// File: rtl/dm_access_m.sv
// M-stage data-memory access unit: decodes MIPS load/store opcodes, writes byte/half/word
// lanes into a word-addressed RAM and registers the extended load data plus alignment flags.
module dm_access_m #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] Instruction,
  input  logic [31:0] MemAddr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData_W,
  output logic        AdEL_W,
  output logic        AdES_W
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  logic [5:0]        opcode;
  logic              isLoad;
  logic              isStore;
  logic              isSigned;
  size_e             accSize;
  logic              misaligned;
  logic [ADDR_W-1:0] wordIdx;
  logic [3:0]        byteEn;
  logic [31:0]       storeData;
  logic [31:0]       rdWord;
  logic [7:0]        byteSel;
  logic [15:0]       halfSel;
  logic [31:0]       loadExt;

  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       readData_q, readData_d;
  logic              adel_q, adel_d;
  logic              ades_q, ades_d;

  // Upper address bits wrap away and the non-opcode instruction fields are not needed here.
  logic              unusedBits;
  assign unusedBits = ^{Instruction[25:0], MemAddr[31:ADDR_W+2]};

  assign opcode  = Instruction[31:26];
  assign wordIdx = MemAddr[ADDR_W+1:2];

  always_comb begin
    isLoad   = 1'b0;
    isStore  = 1'b0;
    isSigned = 1'b0;
    accSize  = SZ_WORD;
    unique case (opcode)
      OP_LW:   begin isLoad = 1'b1; accSize = SZ_WORD; end
      OP_LH:   begin isLoad = 1'b1; accSize = SZ_HALF; isSigned = 1'b1; end
      OP_LHU:  begin isLoad = 1'b1; accSize = SZ_HALF; end
      OP_LB:   begin isLoad = 1'b1; accSize = SZ_BYTE; isSigned = 1'b1; end
      OP_LBU:  begin isLoad = 1'b1; accSize = SZ_BYTE; end
      OP_SW:   begin isStore = 1'b1; accSize = SZ_WORD; end
      OP_SH:   begin isStore = 1'b1; accSize = SZ_HALF; end
      OP_SB:   begin isStore = 1'b1; accSize = SZ_BYTE; end
      default: begin isLoad = 1'b0; isStore = 1'b0; end
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (accSize)
      SZ_WORD: misaligned = (MemAddr[1:0] != 2'b00);
      SZ_HALF: misaligned = MemAddr[0];
      default: misaligned = 1'b0;
    endcase
  end

  // Store data is given right-justified, so it is replicated across lanes and the byte
  // enables pick which copy lands in the RAM word.
  always_comb begin
    byteEn    = 4'b0000;
    storeData = WriteData;
    case (accSize)
      SZ_BYTE: begin
        storeData = {4{WriteData[7:0]}};
        byteEn    = 4'b0001 << MemAddr[1:0];
      end
      SZ_HALF: begin
        storeData = {2{WriteData[15:0]}};
        byteEn    = MemAddr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        storeData = WriteData;
        byteEn    = 4'b1111;
      end
    endcase
    if (!isStore || misaligned) begin
      byteEn = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) begin
          mem_q[wordIdx][8*b +: 8] <= storeData[8*b +: 8];
        end
      end
    end
  end

  assign rdWord  = mem_q[wordIdx];
  assign byteSel = rdWord[{MemAddr[1:0], 3'b000} +: 8];
  assign halfSel = MemAddr[1] ? rdWord[31:16] : rdWord[15:0];

  always_comb begin
    loadExt = rdWord;
    case (accSize)
      SZ_BYTE: loadExt = isSigned ? {{24{byteSel[7]}}, byteSel} : {24'h0, byteSel};
      SZ_HALF: loadExt = isSigned ? {{16{halfSel[15]}}, halfSel} : {16'h0, halfSel};
      default: loadExt = rdWord;
    endcase
  end

  // Anything other than an aligned load clears the data register when the stage advances.
  always_comb begin
    readData_d = readData_q;
    adel_d     = adel_q;
    ades_d     = ades_q;
    if (en) begin
      readData_d = (isLoad && !misaligned) ? loadExt : 32'h0;
      adel_d     = isLoad && misaligned;
      ades_d     = isStore && misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readData_q <= '0;
      adel_q     <= 1'b0;
      ades_q     <= 1'b0;
    end else begin
      readData_q <= readData_d;
      adel_q     <= adel_d;
      ades_q     <= ades_d;
    end
  end

  assign ReadData_W = readData_q;
  assign AdEL_W     = adel_q;
  assign AdES_W     = ades_q;

endmodule

// File: tb/tb_dm_access_m.sv
// Bench for dm_access_m: directed vector table, then random traffic checked against a
// byte-array memory model.
module tb_dm_access_m;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;
  localparam int NBYTES = DEPTH * 4;

  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] LH  = 6'h21;
  localparam logic [5:0] LHU = 6'h25;
  localparam logic [5:0] LB  = 6'h20;
  localparam logic [5:0] LBU = 6'h24;
  localparam logic [5:0] SW  = 6'h2B;
  localparam logic [5:0] SH  = 6'h29;
  localparam logic [5:0] SB  = 6'h28;
  localparam logic [5:0] NOP = 6'h0F;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [31:0] Instruction;
  logic [31:0] MemAddr;
  logic [31:0] WriteData;
  logic [31:0] ReadData_W;
  logic        AdEL_W;
  logic        AdES_W;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mdl [NBYTES];
  logic [31:0] mRd;
  logic        mAdel;
  logic        mAdes;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        en;
    logic        rst;
    logic [31:0] expRd;
    logic        expAdel;
    logic        expAdes;
  } vec_t;

  vec_t vecs[$];

  dm_access_m #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .Instruction(Instruction),
    .MemAddr    (MemAddr),
    .WriteData  (WriteData),
    .ReadData_W (ReadData_W),
    .AdEL_W     (AdEL_W),
    .AdES_W     (AdES_W)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkVec(logic [5:0] op, logic [31:0] addr, logic [31:0] wdata,
                                 logic e, logic r, logic [31:0] rd, logic adel, logic ades);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.en = e; v.rst = r;
    v.expRd = rd; v.expAdel = adel; v.expAdes = ades;
    return v;
  endfunction

  // Reference: byte-addressed memory, sizes and alignment derived directly from the opcode.
  task automatic modelStep(input logic r, input logic e, input logic [31:0] ins,
                           input logic [31:0] a, input logic [31:0] wd);
    int          base;
    int          sz;
    bit          ld;
    bit          st;
    bit          sgn;
    logic [31:0] v;
    if (r) begin
      for (int i = 0; i < NBYTES; i++) mdl[i] = 8'h0;
      mRd = 0; mAdel = 0; mAdes = 0;
      return;
    end
    if (!e) return;
    ld = 0; st = 0; sgn = 0; sz = 4;
    case (ins[31:26])
      LW:  begin ld = 1; sz = 4; end
      LH:  begin ld = 1; sz = 2; sgn = 1; end
      LHU: begin ld = 1; sz = 2; end
      LB:  begin ld = 1; sz = 1; sgn = 1; end
      LBU: begin ld = 1; sz = 1; end
      SW:  begin st = 1; sz = 4; end
      SH:  begin st = 1; sz = 2; end
      SB:  begin st = 1; sz = 1; end
      default: ;
    endcase
    mRd = 0; mAdel = 0; mAdes = 0;
    base = int'(a & (NBYTES - 1));
    if ((ld || st) && (base % sz != 0)) begin
      mAdel = ld; mAdes = st;
      return;
    end
    if (ld) begin
      v = 0;
      for (int k = sz - 1; k >= 0; k--) v = (v << 8) | {24'h0, mdl[base + k]};
      if (sgn && sz == 1) v = {{24{v[7]}}, v[7:0]};
      if (sgn && sz == 2) v = {{16{v[15]}}, v[15:0]};
      mRd = v;
    end
    if (st) begin
      for (int k = 0; k < sz; k++) mdl[base + k] = wd[8*k +: 8];
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [31:0] ins,
                               input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    reset = r; en = e; Instruction = ins; MemAddr = a; WriteData = wd;
    @(posedge clk);
    #1;
    modelStep(r, e, ins, a, wd);
  endtask

  task automatic checkOutput(input string tag, input int idx, input logic [31:0] rd,
                             input logic adel, input logic ades);
    checks++;
    if (ReadData_W !== rd) begin
      errors++;
      $display("[TB] FAIL %s[%0d] ReadData_W: got %h want %h", tag, idx, ReadData_W, rd);
    end
    checks++;
    if (AdEL_W !== adel) begin
      errors++;
      $display("[TB] FAIL %s[%0d] AdEL_W: got %b want %b", tag, idx, AdEL_W, adel);
    end
    checks++;
    if (AdES_W !== ades) begin
      errors++;
      $display("[TB] FAIL %s[%0d] AdES_W: got %b want %b", tag, idx, AdES_W, ades);
    end
  endtask

  initial begin
    logic [5:0]  opList [12];
    logic [31:0] rnd;
    logic [31:0] ins;
    opList = '{LW, LH, LHU, LB, LBU, SW, SH, SB, 6'h00, 6'h0F, 6'h08, 6'h22};

    reset = 1'b1; en = 1'b0; Instruction = 0; MemAddr = 0; WriteData = 0;

    vecs.push_back(mkVec(NOP, 32'h0,    32'h0,        1, 1, 32'h0,        0, 0));
    vecs.push_back(mkVec(NOP, 32'h0,    32'h0,        0, 1, 32'h0,        0, 0));
    vecs.push_back(mkVec(LW,  32'h10,   32'h0,        1, 0, 32'h0,        0, 0));
    vecs.push_back(mkVec(SW,  32'h10,   32'h12345678, 1, 0, 32'h0,        0, 0));
    vecs.push_back(mkVec(LW,  32'h10,   32'h0,        1, 0, 32'h12345678, 0, 0));
    vecs.push_back(mkVec(SB,  32'h11,   32'hFFFFFFAB, 1, 0, 32'h0,        0, 0));
    vecs.push_back(mkVec(LW,  32'h10,   32'h0,        1, 0, 32'h1234AB78, 0, 0));
    vecs.push_back(mkVec(LB,  32'h11,   32'h0,        1, 0, 32'hFFFFFFAB, 0, 0));
    vecs.push_back(mkVec(LBU, 32'h11,   32'h0,        1, 0, 32'h000000AB, 0, 0));
    vecs.push_back(mkVec(SH,  32'h12,   32'h77778001, 1, 0, 32'h0,        0, 0));
    vecs.push_back(mkVec(LH,  32'h12,   32'h0,        1, 0, 32'hFFFF8001, 0, 0));
    vecs.push_back(mkVec(LHU, 32'h12,   32'h0,        1, 0, 32'h00008001, 0, 0));
    vecs.push_back(mkVec(LW,  32'h10,   32'h0,        1, 0, 32'h8001AB78, 0, 0));
    vecs.push_back(mkVec(SW,  32'h13,   32'hDEADBEEF, 1, 0, 32'h0,        0, 1));
    vecs.push_back(mkVec(LW,  32'h10,   32'h0,        1, 0, 32'h8001AB78, 0, 0));
    vecs.push_back(mkVec(LH,  32'h11,   32'h0,        1, 0, 32'h0,        1, 0));
    vecs.push_back(mkVec(LW,  32'h10,   32'h0,        1, 0, 32'h8001AB78, 0, 0));
    vecs.push_back(mkVec(SW,  32'h20,   32'hCAFEF00D, 0, 0, 32'h8001AB78, 0, 0));
    vecs.push_back(mkVec(LH,  32'h11,   32'h0,        1, 0, 32'h0,        1, 0));
    vecs.push_back(mkVec(LW,  32'h10,   32'h0,        0, 0, 32'h0,        1, 0));
    vecs.push_back(mkVec(NOP, 32'h10,   32'h0,        1, 0, 32'h0,        0, 0));
    vecs.push_back(mkVec(LW,  32'h20,   32'h0,        1, 0, 32'h0,        0, 0));
    vecs.push_back(mkVec(SW,  32'h50,   32'h00000077, 1, 0, 32'h0,        0, 0));
    vecs.push_back(mkVec(NOP, 32'h50,   32'h00000099, 1, 0, 32'h0,        0, 0));
    vecs.push_back(mkVec(LW,  32'h50,   32'h0,        1, 0, 32'h00000077, 0, 0));
    vecs.push_back(mkVec(SW,  32'h1004, 32'h55AA33CC, 1, 0, 32'h0,        0, 0));
    vecs.push_back(mkVec(LW,  32'h4,    32'h0,        1, 0, 32'h55AA33CC, 0, 0));
    vecs.push_back(mkVec(LBU, 32'h7,    32'h0,        1, 0, 32'h00000055, 0, 0));
    vecs.push_back(mkVec(LB,  32'h6,    32'h0,        1, 0, 32'hFFFFFFAA, 0, 0));
    vecs.push_back(mkVec(LHU, 32'h6,    32'h0,        1, 0, 32'h000055AA, 0, 0));
    vecs.push_back(mkVec(SW,  32'h30,   32'h11112222, 1, 1, 32'h0,        0, 0));
    vecs.push_back(mkVec(LW,  32'h30,   32'h0,        1, 0, 32'h0,        0, 0));
    vecs.push_back(mkVec(LW,  32'h4,    32'h0,        1, 0, 32'h0,        0, 0));
    vecs.push_back(mkVec(LW,  32'h10,   32'h0,        1, 0, 32'h0,        0, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].en, {vecs[i].op, 26'h15A3C}, vecs[i].addr,
                    vecs[i].wdata);
      checkOutput("vec", i, vecs[i].expRd, vecs[i].expAdel, vecs[i].expAdes);
    end

    // Random traffic over 16 words with random upper address bits to exercise wrapping.
    applyStimulus(1'b1, 1'b1, 32'h0, 32'h0, 32'h0);
    for (int n = 0; n < 500; n++) begin
      rnd = $urandom();
      ins = {opList[$urandom_range(0, 11)], rnd[25:0]};
      rnd = $urandom() & 32'hFFFFF03F;
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0), ins, rnd,
                    $urandom());
      checkOutput("rand", n, mRd, mAdel, mAdes);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
